mips_main_ctrl: RTL and testbench

MIPS_MAIN_CTRL -- requirements
Module: mips_main_ctrl

---
 rtl/mips_main_ctrl.sv | 153 +++++++++++++++
 tb/tb_mips_main_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_main_ctrl.sv
// Main control unit for a multicycle MIPS datapath: 12-state Moore FSM
// with optional memory-ready stalling and combinational PC enable.
module mips_main_ctrl #(
    parameter bit STALL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] aluop,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       branch,
    output logic       pcwrite,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    state_t cur_state;
    state_t nxt_state;
    logic   rdy;

    assign rdy   = STALL_EN ? mem_ready : 1'b1;
    assign state = cur_state;
    // Branch qualification is taken from the live zero flag in the same cycle.
    assign pcen  = rst_n & (pcwrite | (branch & zero));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state and Moore output decode; unencoded states fall back to FETCH.
    always_comb begin
        nxt_state  = S_FETCH;
        aluop      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        branch     = 1'b0;
        pcwrite    = 1'b0;
        pcsrc      = 2'b00;
        illegal_op = 1'b0;
        case (cur_state)
            S_FETCH: begin
                alusrcb   = 2'b01;
                irwrite   = rdy & rst_n;
                pcwrite   = rdy & rst_n;
                nxt_state = rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: nxt_state = S_MEMADR;
                    OP_RTYPE:     nxt_state = S_RTYPEEX;
                    OP_BEQ:       nxt_state = S_BEQEX;
                    OP_ADDI:      nxt_state = S_ADDIEX;
                    OP_J:         nxt_state = S_JEX;
                    default: begin
                        nxt_state  = S_FETCH;
                        illegal_op = rst_n;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                nxt_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord      = 1'b1;
                nxt_state = rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                memwrite  = 1'b1;
                nxt_state = rdy ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: begin
                alusrca   = 1'b1;
                aluop     = 2'b10;
                nxt_state = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                nxt_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
            end
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: nxt_state = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mips_main_ctrl.sv
// Scoreboard bench for mips_main_ctrl: the stimulus process queues the
// expected output vector per cycle, a monitor pops and compares it.
module tb_mips_main_ctrl;

    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] RT  = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] ADI = 6'b001000;
    localparam logic [5:0] JMP = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    typedef struct {
        int          step;
        logic [20:0] vec;
    } sb_entry_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       branch;
    logic       pcwrite;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       illegal_op;
    logic [3:0] state;

    sb_entry_t sb[$];
    int checks   = 0;
    int failures = 0;
    int step     = 0;

    mips_main_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .aluop      (aluop),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .branch     (branch),
        .pcwrite    (pcwrite),
        .pcsrc      (pcsrc),
        .pcen       (pcen),
        .illegal_op (illegal_op),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Output table written from the state descriptions:
    // {state, aluop, alusrca, alusrcb, iord, memwrite, irwrite, regdst,
    //  memtoreg, regwrite, branch, pcwrite, pcsrc, pcen, illegal_op}
    function automatic logic [20:0] exp_vec(input logic [3:0] st, input logic [5:0] o,
                                            input logic mr, input logic z, input logic rn);
        logic [1:0] ao, bsel, ps;
        logic a, io, mw, irw, rd, m2r, rw, br, pw, ill, pe;
        ao = 2'b00; bsel = 2'b00; ps = 2'b00;
        a = 1'b0; io = 1'b0; mw = 1'b0; irw = 1'b0; rd = 1'b0; m2r = 1'b0;
        rw = 1'b0; br = 1'b0; pw = 1'b0; ill = 1'b0;
        case (st)
            4'd0:  begin bsel = 2'b01; irw = mr & rn; pw = mr & rn; end
            4'd1:  begin
                bsel = 2'b11;
                ill  = !(o == LW || o == SW || o == RT || o == BEQ || o == ADI || o == JMP);
            end
            4'd2:  begin a = 1'b1; bsel = 2'b10; end
            4'd3:  io = 1'b1;
            4'd4:  begin m2r = 1'b1; rw = 1'b1; end
            4'd5:  begin io = 1'b1; mw = 1'b1; end
            4'd6:  begin a = 1'b1; ao = 2'b10; end
            4'd7:  begin rd = 1'b1; rw = 1'b1; end
            4'd8:  begin a = 1'b1; ao = 2'b01; ps = 2'b01; br = 1'b1; end
            4'd9:  begin a = 1'b1; bsel = 2'b10; end
            4'd10: rw = 1'b1;
            4'd11: begin ps = 2'b10; pw = 1'b1; end
            default: ;
        endcase
        pe = rn & (pw | (br & z));
        return {st, ao, a, bsel, io, mw, irw, rd, m2r, rw, br, pw, ps, pe, ill};
    endfunction

    // Drive one cycle's inputs shortly after the rising edge and queue its expected outputs.
    task automatic cyc(input logic [3:0] st, input logic [5:0] o, input logic mr,
                       input logic z, input logic rn);
        @(posedge clk);
        #1;
        op        = o;
        mem_ready = mr;
        zero      = z;
        rst_n     = rn;
        sb.push_back('{step: step, vec: exp_vec(st, o, mr, z, rn)});
        step++;
    endtask

    // Monitor: sample mid-cycle (or just after an asynchronous reset) and compare.
    initial begin
        sb_entry_t   e;
        logic [20:0] act;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {state, aluop, alusrca, alusrcb, iord, memwrite, irwrite, regdst,
                       memtoreg, regwrite, branch, pcwrite, pcsrc, pcen, illegal_op};
                checks++;
                if (act !== e.vec) begin
                    failures++;
                    $display("FAIL step%0d: state=%0d got=%06h expected=%06h (exp state %0d)",
                             e.step, act[20:17], act, e.vec, e.vec[20:17]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; op = LW; zero = 1'b0; mem_ready = 1'b1;
        // reset held with mem_ready=1: FETCH, irwrite/pcwrite/pcen forced low
        cyc(4'd0, LW, 1'b1, 1'b0, 1'b0);
        cyc(4'd0, LW, 1'b1, 1'b0, 1'b0);
        // lw, no stalls: 0,1,2,3,4
        cyc(4'd0, LW, 1'b1, 1'b0, 1'b1);
        cyc(4'd1, LW, 1'b1, 1'b0, 1'b1);
        cyc(4'd2, LW, 1'b1, 1'b0, 1'b1);
        cyc(4'd3, LW, 1'b1, 1'b0, 1'b1);
        cyc(4'd4, LW, 1'b1, 1'b0, 1'b1);
        // sw with two wait cycles in MEMWR
        cyc(4'd0, SW, 1'b1, 1'b0, 1'b1);
        cyc(4'd1, SW, 1'b1, 1'b0, 1'b1);
        cyc(4'd2, SW, 1'b1, 1'b0, 1'b1);
        cyc(4'd5, SW, 1'b0, 1'b0, 1'b1);
        cyc(4'd5, SW, 1'b0, 1'b0, 1'b1);
        cyc(4'd5, SW, 1'b1, 1'b0, 1'b1);
        // beq taken then not taken
        cyc(4'd0, BEQ, 1'b1, 1'b1, 1'b1);
        cyc(4'd1, BEQ, 1'b1, 1'b1, 1'b1);
        cyc(4'd8, BEQ, 1'b1, 1'b1, 1'b1);
        cyc(4'd0, BEQ, 1'b1, 1'b0, 1'b1);
        cyc(4'd1, BEQ, 1'b1, 1'b0, 1'b1);
        cyc(4'd8, BEQ, 1'b1, 1'b0, 1'b1);
        // R-type, addi, j
        cyc(4'd0, RT, 1'b1, 1'b0, 1'b1);
        cyc(4'd1, RT, 1'b1, 1'b0, 1'b1);
        cyc(4'd6, RT, 1'b1, 1'b0, 1'b1);
        cyc(4'd7, RT, 1'b1, 1'b0, 1'b1);
        cyc(4'd0, ADI, 1'b1, 1'b0, 1'b1);
        cyc(4'd1, ADI, 1'b1, 1'b0, 1'b1);
        cyc(4'd9, ADI, 1'b1, 1'b0, 1'b1);
        cyc(4'd10, ADI, 1'b1, 1'b0, 1'b1);
        cyc(4'd0, JMP, 1'b1, 1'b1, 1'b1);
        cyc(4'd1, JMP, 1'b1, 1'b1, 1'b1);
        cyc(4'd11, JMP, 1'b1, 1'b1, 1'b1);
        // illegal opcode: one DECODE cycle flagged, back to FETCH
        cyc(4'd0, BAD, 1'b1, 1'b0, 1'b1);
        cyc(4'd1, BAD, 1'b1, 1'b0, 1'b1);
        // lw with a FETCH stall, a MEMRD stall and op changing after MEMADR
        cyc(4'd0, LW, 1'b0, 1'b0, 1'b1);
        cyc(4'd0, LW, 1'b1, 1'b0, 1'b1);
        cyc(4'd1, LW, 1'b1, 1'b0, 1'b1);
        cyc(4'd2, LW, 1'b1, 1'b0, 1'b1);
        cyc(4'd3, JMP, 1'b0, 1'b0, 1'b1);
        cyc(4'd3, JMP, 1'b1, 1'b0, 1'b1);
        cyc(4'd4, SW, 1'b1, 1'b0, 1'b1);
        // reset asserted mid-MEMRD between clock edges
        cyc(4'd0, LW, 1'b1, 1'b0, 1'b1);
        cyc(4'd1, LW, 1'b1, 1'b0, 1'b1);
        cyc(4'd2, LW, 1'b1, 1'b0, 1'b1);
        cyc(4'd3, LW, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        sb.push_back('{step: step, vec: exp_vec(4'd0, LW, 1'b0, 1'b0, 1'b0)});
        step++;
        rst_n = 1'b0;
        cyc(4'd0, LW, 1'b1, 1'b0, 1'b0);
        cyc(4'd0, LW, 1'b0, 1'b0, 1'b1);
        cyc(4'd0, LW, 1'b1, 1'b0, 1'b1);
        cyc(4'd1, ADI, 1'b1, 1'b0, 1'b1);
        cyc(4'd9, ADI, 1'b1, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #7;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: scoreboard entries left=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
